// File: rtl/rf_pkg.sv
// Shared register-file geometry: used by the write-back arbiter, the register
// file itself and its read-side mux.
package rf_pkg;

  localparam int unsigned RF_ADDR_W = 3;
  localparam int unsigned RF_DATA_W = 16;
  localparam int unsigned RF_DEPTH  = 8;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  // Index width that stays legal when only one requester exists.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps modulo N.
// The pointer state is held by the instantiating module.
module rr_arbiter #(
  parameter int unsigned N    = 3,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  input  logic            hold,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] gnt_idx,
  output logic            gnt_valid
);

  always_comb begin
    logic [IdxW-1:0] cand;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    if (!hold) begin
      for (int unsigned k = 0; k < N; k++) begin
        cand = IdxW'((32'(ptr) + k) % N);
        if (!gnt_valid && req[cand]) begin
          gnt[cand] = 1'b1;
          gnt_idx   = cand;
          gnt_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register-file write port: round-robin grant,
// one registered write per cycle, and a pending-write mask for hazard checks.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DATA_W = RF_DATA_W,
  localparam int unsigned IdxW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_hold,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic [IdxW-1:0]       grant_id,
  output logic [2**ADDR_W-1:0]  pending_mask
);

  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [IdxW-1:0]   grant_id_q, grant_id_d;

  logic [N_REQ-1:0] gnt;
  logic [IdxW-1:0]  gnt_idx;
  logic             gnt_valid;

  rr_arbiter #(
    .N    (N_REQ),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .hold      (wb_hold),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    grant_id_d = grant_id_q;
    if (gnt_valid && !rst) begin
      rr_ptr_d   = (gnt_idx == IdxW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      wr_en_d    = 1'b1;
      wr_addr_d  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
      wr_data_d  = req_data[gnt_idx*DATA_W +: DATA_W];
      grant_id_d = gnt_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      grant_id_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      grant_id_q <= grant_id_d;
    end
  end

  // Mask covers both waiting requests and the write currently on the port.
  always_comb begin
    pending_mask = '0;
    if (!rst) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (req_valid[i]) pending_mask[req_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
      end
      if (wr_en_q) pending_mask[wr_addr_q] = 1'b1;
    end
  end

  assign req_ready = rst ? '0 : gnt;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign grant_id  = grant_id_q;

endmodule
